// File: rtl/lin_pkg.sv
// Shared helpers for the linear gain/offset stage: signed saturation with
// overflow indication and the unity-gain constant for a given gain width.
package lin_pkg;

  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } sat_t;

  function automatic sat_t sat(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (width - 1));
    r.val = value;
    r.ovf = 1'b0;
    if (value > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (value < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  // Gain has DWM-2 fraction bits, so 1.0 sits at bit DWM-2.
  function automatic int unsigned unity(input int dwm);
    return 32'd1 << (dwm - 2);
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-stream bundle carrying the shared clock/reset; s = source, d = destination.
interface axi4_stream_if #(
  parameter int DW = 14
) (
  input logic ACLK,
  input logic ARESETn
);
  localparam int KW = (DW + 7) / 8;

  logic [DW-1:0] TDATA;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic [KW-1:0] TKEEP;

  modport s (input ACLK, ARESETn, TREADY, output TDATA, TVALID, TLAST, TKEEP);
  modport d (input ACLK, ARESETn, TDATA, TVALID, TLAST, TKEEP, output TREADY);

endinterface

// File: rtl/lin_gain_ofs.sv
// Two-stage streaming y = sat(floor(x*gain/2**(DWM-2)) + offset) with full
// valid/ready backpressure and saturation status.
module lin_gain_ofs
  import lin_pkg::*;
#(
  parameter int DWI = 14,
  parameter int DWO = 14,
  parameter int DWM = 16,
  parameter int DWC = 32
) (
  axi4_stream_if.d              sti,
  axi4_stream_if.s              sto,
  input  logic                  ctl_rst,
  input  logic signed [DWM-1:0] cfg_mul,
  input  logic signed [DWO-1:0] cfg_sum,
  output logic                  sts_ovf,
  output logic [DWC-1:0]        sts_cnt
);
  localparam int SHIFT = DWM - 2;
  localparam int PW    = DWI + DWM;
  localparam int QW    = PW - SHIFT;
  localparam int SW    = ((DWI + 2 > DWO) ? DWI + 2 : DWO) + 1;

  logic                  s1_vld, s1_last;
  logic signed [PW-1:0]  s1_prod;
  logic                  s2_vld, s2_last, s2_sat;
  logic signed [DWO-1:0] s2_data;
  logic                  adv1, adv2;

  logic signed [DWI-1:0] x;
  logic signed [PW-1:0]  prod;
  logic signed [QW-1:0]  quo;
  logic signed [SW-1:0]  sum;
  sat_t                  sres;
  logic                  unused_bits;

  assign x    = sti.TDATA;
  assign prod = $signed({{DWM{x[DWI-1]}}, x}) * $signed({{DWI{cfg_mul[DWM-1]}}, cfg_mul});
  // Taking the upper bits is an arithmetic shift, i.e. floor toward -inf.
  assign quo  = s1_prod[PW-1:SHIFT];
  assign sum  = {{(SW-QW){quo[QW-1]}}, quo} + {{(SW-DWO){cfg_sum[DWO-1]}}, cfg_sum};
  assign sres = sat(64'(sum), DWO);

  assign adv2 = ~s2_vld | sto.TREADY;
  assign adv1 = ~s1_vld | adv2;
  // Flush keeps the input open so upstream drains instead of stalling.
  assign sti.TREADY = adv1 | ctl_rst;

  assign sto.TDATA  = s2_data;
  assign sto.TVALID = s2_vld;
  assign sto.TLAST  = s2_last;
  assign sto.TKEEP  = '1;

  assign unused_bits = ^{sti.TKEEP, s1_prod[SHIFT-1:0], sres.val[63:DWO]};

  always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
    if (!sti.ARESETn) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_sat  <= 1'b0;
      s2_data <= '0;
      sts_ovf <= 1'b0;
      sts_cnt <= '0;
    end else if (ctl_rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      sts_ovf <= 1'b0;
      sts_cnt <= '0;
    end else begin
      if (adv1) begin
        s1_vld <= sti.TVALID;
        if (sti.TVALID) begin
          s1_prod <= prod;
          s1_last <= sti.TLAST;
        end
      end
      if (adv2) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_data <= sres.val[DWO-1:0];
          s2_last <= s1_last;
          s2_sat  <= sres.ovf;
        end
      end
      if (s2_vld && sto.TREADY && s2_sat) begin
        sts_ovf <= 1'b1;
        if (sts_cnt != '1) sts_cnt <= sts_cnt + DWC'(1);
      end
    end
  end

endmodule

// File: tb/tb_lin_gain_ofs.sv
// Self-checking bench for lin_gain_ofs: directed literals plus random traffic
// scored against a plain-arithmetic model of the gain/offset formula.
module tb_lin_gain_ofs;
  import lin_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              ctl_rst;
  logic signed [15:0] cfg_mul;
  logic signed [13:0] cfg_sum;
  logic              sts_ovf;
  logic [31:0]       sts_cnt;

  axi4_stream_if #(.DW(14)) sti (.ACLK(clk), .ARESETn(rst_n));
  axi4_stream_if #(.DW(14)) sto (.ACLK(clk), .ARESETn(rst_n));

  lin_gain_ofs dut (
    .sti     (sti),
    .sto     (sto),
    .ctl_rst (ctl_rst),
    .cfg_mul (cfg_mul),
    .cfg_sum (cfg_sum),
    .sts_ovf (sts_ovf),
    .sts_cnt (sts_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y;
    bit last;
    bit s;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_out = 0;
  int   sat_cnt_exp = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Real-number rule: floor of x*mul/16384 plus offset, clamped to 14 bits.
  function automatic void model(input int xv, input int mul, input int ofs,
                                output int y, output bit s);
    longint p, q, t;
    p = longint'(xv) * longint'(mul);
    q = p / 16384;
    if ((p % 16384) != 0 && p < 0) q = q - 1;
    t = q + ofs;
    s = 1'b1;
    if (t > 8191) y = 8191;
    else if (t < -8192) y = -8192;
    else begin
      y = int'(t);
      s = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst_n && chk_en) begin
      if (sto.TVALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", $signed(sto.TDATA), 99999);
        end else begin
          check("out_data", $signed(sto.TDATA), exp_q[0].y);
          check("out_last", sto.TLAST, exp_q[0].last);
          if (sto.TREADY) begin
            e = exp_q.pop_front();
            n_out++;
            if (e.s) sat_cnt_exp++;
          end
        end
      end
      if (sti.TVALID && sti.TREADY && !ctl_rst) begin
        model(int'($signed(sti.TDATA)), int'(cfg_mul), int'(cfg_sum), e.y, e.s);
        e.last = sti.TLAST;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drain();
    int b;
    b = 0;
    sto.TREADY = 1'b1;
    while ((exp_q.size() != 0 || sto.TVALID) && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", b >= 200, 0);
  endtask

  task automatic run1(input string nm, input int xv, input int mul, input int ofs,
                      input int expv);
    @(negedge clk);
    cfg_mul    = 16'(mul);
    cfg_sum    = 14'(ofs);
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'(xv);
    sti.TLAST  = 1'b0;
    @(negedge clk);
    sti.TVALID = 1'b0;
    @(negedge clk);
    #3;
    check(nm, $signed(sto.TDATA), expv);
    check({nm, "_vld"}, sto.TVALID, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[4];
    int idx, base, acc, cyc, blk_acc;
    bit hs;

    rst_n      = 1'b0;
    ctl_rst    = 1'b0;
    cfg_mul    = 16'(unity(16));
    cfg_sum    = '0;
    sti.TVALID = 1'b0;
    sti.TDATA  = '0;
    sti.TLAST  = 1'b0;
    sti.TKEEP  = '1;
    sto.TREADY = 1'b1;

    repeat (3) @(negedge clk);
    #3;
    check("rst_tvalid", sto.TVALID, 0);
    check("rst_tdata", sto.TDATA, 0);
    check("rst_tlast", sto.TLAST, 0);
    check("rst_ovf", sts_ovf, 0);
    check("rst_cnt", sts_cnt, 0);
    check("rst_sti_ready", sti.TREADY, 1);
    check("tkeep_ones", sto.TKEEP, 3);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Unity pass-through with latency probes.
    vals = '{1000, -1000, 8191, -8192};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sti.TVALID = 1'b1;
      sti.TDATA  = 14'(vals[i]);
      #3;
      if (i == 1) check("lat_cycle1_vld", sto.TVALID, 0);
      if (i == 2) begin
        check("lat_cycle2_vld", sto.TVALID, 1);
        check("lat_cycle2_data", $signed(sto.TDATA), 1000);
      end
    end
    @(negedge clk);
    sti.TVALID = 1'b0;
    drain();
    check("unity_ovf", sts_ovf, 0);

    run1("neg_gain_ofs", 100, -16384, 50, -50);
    run1("floor_pos", 3, 24576, 0, 4);
    run1("floor_neg", -3, 24576, 0, -5);
    run1("sat_hi", 8191, 32767, 0, 8191);
    run1("sat_lo", -8192, 32767, 0, -8192);
    run1("sat_negneg", -8192, -32768, 0, 8191);
    drain();
    check("sat_ovf", sts_ovf, 1);
    check("sat_cnt", sts_cnt, 3);

    // Flush: inputs presented during ctl_rst are discarded.
    @(negedge clk);
    ctl_rst    = 1'b1;
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'd77;
    #3;
    check("flush_sti_ready", sti.TREADY, 1);
    @(negedge clk);
    ctl_rst    = 1'b0;
    sti.TVALID = 1'b0;
    #3;
    check("flush_ovf", sts_ovf, 0);
    check("flush_cnt", sts_cnt, 0);
    sat_cnt_exp = 0;
    drain();

    // Saturated beat handshakes in the same cycle as ctl_rst: clear wins.
    cfg_mul = 16'sd32767;
    @(negedge clk);
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'd8191;
    @(negedge clk);
    sti.TVALID = 1'b0;
    @(negedge clk);
    ctl_rst = 1'b1;
    #3;
    check("coll_vld", sto.TVALID, 1);
    @(negedge clk);
    ctl_rst = 1'b0;
    #3;
    check("coll_cnt", sts_cnt, 0);
    check("coll_ovf", sts_ovf, 0);
    sat_cnt_exp = 0;
    drain();

    // Config sampled per stage: gain at S1 entry, offset at S2 entry.
    chk_en  = 1'b0;
    cfg_mul = 16'(unity(16));
    cfg_sum = '0;
    @(negedge clk);
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'd100;
    @(negedge clk);
    cfg_mul = -16'sd16384;
    cfg_sum = 14'sd7;
    @(negedge clk);
    sti.TVALID = 1'b0;
    cfg_sum    = 14'sd1000;
    #3;
    check("stage_a", $signed(sto.TDATA), 107);
    @(negedge clk);
    #3;
    check("stage_b", $signed(sto.TDATA), 900);
    drain();
    chk_en  = 1'b1;

    // Backpressure: TREADY low for cycles 3..12 of an 8-beat packet.
    cfg_mul = 16'(unity(16));
    cfg_sum = '0;
    base = n_out;
    idx  = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      sto.TREADY = !(c >= 3 && c <= 12);
      if (idx < 8) begin
        sti.TVALID = 1'b1;
        sti.TDATA  = 14'(idx + 1);
        sti.TLAST  = (idx == 7);
      end else begin
        sti.TVALID = 1'b0;
        sti.TLAST  = 1'b0;
      end
      #3;
      if (c == 3 || c == 12) check("bp_sti_ready_low", sti.TREADY, 0);
      if (c == 13) check("bp_sti_ready_resume", sti.TREADY, 1);
      if (sti.TVALID && sti.TREADY) idx++;
    end
    drain();
    check("bp_beats_in", idx, 8);
    check("bp_beats_out", n_out - base, 8);

    // Random traffic, config changed every 50 accepted beats.
    @(negedge clk);
    ctl_rst = 1'b1;
    @(negedge clk);
    ctl_rst = 1'b0;
    sat_cnt_exp = 0;
    acc = 0;
    cyc = 0;
    for (int blk = 0; blk < 20; blk++) begin
      cfg_mul = 16'($urandom_range(0, 65535));
      cfg_sum = 14'($urandom_range(0, 16383));
      blk_acc = 0;
      hs = 1'b0;
      while (blk_acc < 50 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (hs) sti.TVALID = 1'b0;
        sto.TREADY = ($urandom_range(0, 9) < 7);
        if (!sti.TVALID && $urandom_range(0, 3) != 0) begin
          sti.TVALID = 1'b1;
          sti.TDATA  = 14'($urandom_range(0, 16383));
          sti.TLAST  = 1'($urandom_range(0, 1));
        end
        #3;
        hs = sti.TVALID && sti.TREADY;
        if (hs) begin
          blk_acc++;
          acc++;
        end
      end
      @(negedge clk);
      sti.TVALID = 1'b0;
      drain();
    end
    check("rand_beats", acc, 1000);
    check("rand_sat_cnt", sts_cnt, sat_cnt_exp);
    check("rand_ovf", sts_ovf, sat_cnt_exp != 0);

    // Async reset with two beats in flight.
    chk_en     = 1'b0;
    cfg_mul    = 16'(unity(16));
    cfg_sum    = '0;
    sto.TREADY = 1'b0;
    @(negedge clk);
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'd11;
    @(negedge clk);
    sti.TDATA  = 14'd22;
    @(negedge clk);
    sti.TVALID = 1'b0;
    #3;
    check("arst_inflight", sto.TVALID, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", sto.TVALID, 0);
    check("arst_cnt", sts_cnt, 0);
    check("arst_ovf", sts_ovf, 0);
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    sto.TREADY = 1'b1;
    exp_q.delete();
    chk_en     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #3;
      check("post_rst_idle", sto.TVALID, 0);
    end
    @(negedge clk);
    sti.TVALID = 1'b1;
    sti.TDATA  = 14'd1234;
    @(negedge clk);
    sti.TVALID = 1'b0;
    @(negedge clk);
    #3;
    check("post_rst_first", $signed(sto.TDATA), 1234);
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
